// File: rtl/spi_controller.sv
// Mode 0 SPI controller: one byte per CS_n frame, MSB first, SCLK = clk / (2*CLK_DIV).
// Build option SPI_CTRL_BURST_EN: accept the next byte during HOLD and keep CS_n low.
//
// state | meaning
// IDLE  | ready for a byte, pins idle
// SETUP | CS_n low, first bit on PICO, SCLK low for D cycles
// XFER  | 16 SCLK half-periods of D cycles
// HOLD  | CS_n low, SCLK low for D cycles before release
// GAP   | CS_n high, not ready, D cycles
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic       i_txDataValid,
  input  logic [7:0] i_txData,
  output logic       o_txReady,
  output logic       o_rxDataValid,
  output logic [7:0] o_rxData,
  output logic       o_SPI_CLK,
  output logic       o_SPI_PICO,
  input  logic       i_SPI_POCI,
  output logic       o_SPI_CS_n
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
`ifdef SPI_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] half, half_nxt;
  logic [7:0] tx_sr, tx_nxt;
  logic [7:0] rx_sr, rx_nxt;
  logic       cs_n_nxt, sclk_nxt, pico_nxt, ready_nxt, rxv_nxt;
  logic [7:0] rxd_nxt;
  logic       cnt_done;
  logic       accept;

  assign cnt_done = (cnt == 8'd0);
  assign accept   = i_txDataValid && o_txReady;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      half          <= 4'd0;
      tx_sr         <= 8'd0;
      rx_sr         <= 8'd0;
      o_SPI_CS_n    <= 1'b1;
      o_SPI_CLK     <= 1'b0;
      o_SPI_PICO    <= 1'b0;
      o_txReady     <= 1'b1;
      o_rxDataValid <= 1'b0;
      o_rxData      <= 8'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      half          <= half_nxt;
      tx_sr         <= tx_nxt;
      rx_sr         <= rx_nxt;
      o_SPI_CS_n    <= cs_n_nxt;
      o_SPI_CLK     <= sclk_nxt;
      o_SPI_PICO    <= pico_nxt;
      o_txReady     <= ready_nxt;
      o_rxDataValid <= rxv_nxt;
      o_rxData      <= rxd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    half_nxt  = half;
    tx_nxt    = tx_sr;
    rx_nxt    = rx_sr;
    cs_n_nxt  = o_SPI_CS_n;
    sclk_nxt  = o_SPI_CLK;
    pico_nxt  = o_SPI_PICO;
    ready_nxt = o_txReady;
    rxv_nxt   = 1'b0;
    rxd_nxt   = o_rxData;
    case (state)
      IDLE: begin
        if (accept) begin
          tx_nxt    = i_txData;
          pico_nxt  = i_txData[7];
          cs_n_nxt  = 1'b0;
          ready_nxt = 1'b0;
          cnt_nxt   = DIV_LAST;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          cnt_nxt   = DIV_LAST;
          half_nxt  = 4'd0;
          state_nxt = XFER;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      XFER: begin
        if (cnt_done) begin
          cnt_nxt  = DIV_LAST;
          sclk_nxt = ~o_SPI_CLK;
          half_nxt = half + 4'd1;
          // Falling edge: sample late in the high phase, then present the next bit.
          if (o_SPI_CLK) begin
            rx_nxt = {rx_sr[6:0], i_SPI_POCI};
            if (half != 4'd15) begin
              pico_nxt = tx_sr[6];
              tx_nxt   = {tx_sr[6:0], 1'b0};
            end
          end
          if (half == 4'd15) begin
            ready_nxt = BURST;
            state_nxt = HOLD;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (BURST && accept) begin
          rxd_nxt   = rx_sr;
          rxv_nxt   = 1'b1;
          tx_nxt    = i_txData;
          pico_nxt  = i_txData[7];
          ready_nxt = 1'b0;
          cnt_nxt   = DIV_LAST;
          state_nxt = SETUP;
        end else if (cnt_done) begin
          cs_n_nxt  = 1'b1;
          pico_nxt  = 1'b0;
          rxd_nxt   = rx_sr;
          rxv_nxt   = 1'b1;
          ready_nxt = 1'b0;
          cnt_nxt   = DIV_LAST;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt_done) begin
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
